// File: rtl/fastpath_cfg_pkg.sv
// Shared constants for the fast-path opcode table loader: op codes, header
// field positions, table/bitmap geometry and FSM state encodings.
package fastpath_cfg_pkg;

    localparam int TAB_AW = 12;
    localparam int SUB_IW = 8;

    localparam logic [3:0] OP_TAB = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_CLR = 4'h3;

    localparam int HDR_OP_LO    = 60;
    localparam int HDR_START_LO = 48;
    localparam int HDR_CNT_LO   = 32;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_QUIESCE = 3'd1;
    localparam state_t S_FETCH   = 3'd2;
    localparam state_t S_UNPACK  = 3'd3;
    localparam state_t S_SUBWR   = 3'd4;
    localparam state_t S_CLEAR   = 3'd5;
    localparam state_t S_FINISH  = 3'd6;

    function automatic logic op_has_payload(input logic [3:0] op);
        return (op == OP_TAB) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/fastpath_byte_unpacker.sv
// Turns one 64-bit word into consecutive byte writes (LSB first) at
// incrementing addresses; a long span with zero data doubles as a table clear.
module fastpath_byte_unpacker
    import fastpath_cfg_pkg::*;
#(
    parameter int AW = TAB_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [63:0]   word,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] span,
    output logic          wen,
    output logic [AW-1:0] addr,
    output logic [7:0]    data,
    output logic          last
);

    logic [55:0]   shreg;
    logic [AW-1:0] rem;

    // span is the number of writes minus one, so a full-table sweep fits in AW bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen   <= 1'b0;
            addr  <= '0;
            data  <= '0;
            shreg <= '0;
            rem   <= '0;
        end else if (load) begin
            wen   <= 1'b1;
            addr  <= base;
            data  <= word[7:0];
            shreg <= word[63:8];
            rem   <= span;
        end else if (wen && rem != '0) begin
            addr  <= addr + AW'(1);
            data  <= shreg[7:0];
            shreg <= {8'h00, shreg[55:8]};
            rem   <= rem - AW'(1);
        end else begin
            wen   <= 1'b0;
        end
    end

    assign last = wen && (rem == '0);

endmodule

// File: rtl/fastpath_optab_loader.sv
// Config sequencer: unpacks header/payload words into opcode-table byte writes
// and attribute-bitmap chunk writes, quiescing the translator around each command.
// Optional trailer checksum: define FASTPATH_LOADER_CHECKSUM_EN.
module fastpath_optab_loader #(
    parameter int TAB_AW = 12,
    parameter int SUB_IW = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [63:0]       cfg_data,
    output logic              dec_hold,
    input  logic              dec_idle,
    output logic              tab_wen,
    output logic [TAB_AW-1:0] tab_addr,
    output logic [7:0]        tab_data,
    output logic              sub_en,
    output logic [SUB_IW-1:0] sub_idx,
    output logic [63:0]       sub_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import fastpath_cfg_pkg::*;

    state_t            state, nxt, after_word;
    logic [3:0]        op;
    logic [CNT_W-1:0]  cnt;
    logic [TAB_AW-1:0] ptr;
    logic              acc, trailer, up_load, up_last;
    logic [63:0]       up_word;
    logic [TAB_AW-1:0] up_base, up_span;

    logic [3:0]        h_op;
    logic [TAB_AW-1:0] h_start;
    logic [CNT_W-1:0]  h_cnt;
    logic              h_legal;

    assign acc     = cfg_valid && cfg_ready;
    assign h_op    = cfg_data[HDR_OP_LO +: 4];
    assign h_start = cfg_data[HDR_START_LO +: TAB_AW];
    assign h_cnt   = cfg_data[HDR_CNT_LO +: CNT_W];
    assign h_legal = op_has_payload(h_op) || (h_op == OP_CLR);

`ifdef FASTPATH_LOADER_CHECKSUM_EN
    logic [63:0] csum;
    // with the checksum on, the last payload is followed by a trailer fetch
    assign trailer    = (cnt == '0);
    assign after_word = S_FETCH;
`else
    assign trailer    = 1'b0;
    assign after_word = (cnt == '0) ? S_FINISH : S_FETCH;
`endif

    always_comb begin
        nxt     = state;
        up_load = 1'b0;
        up_word = cfg_data;
        up_base = ptr;
        up_span = TAB_AW'(7);
        case (state)
            S_IDLE:
                if (acc) begin
                    if (h_op == OP_CLR || (op_has_payload(h_op) && h_cnt != '0))
                        nxt = S_QUIESCE;
                    else
                        nxt = S_FINISH;
                end
            S_QUIESCE:
                if (dec_idle) begin
                    if (op == OP_CLR) begin
                        nxt     = S_CLEAR;
                        up_load = 1'b1;
                        up_word = '0;
                        up_base = '0;
                        up_span = '1;
                    end else begin
                        nxt = S_FETCH;
                    end
                end
            S_FETCH:
                if (acc) begin
                    if (trailer)
                        nxt = S_FINISH;
                    else if (op == OP_TAB) begin
                        nxt     = S_UNPACK;
                        up_load = 1'b1;
                    end else
                        nxt = S_SUBWR;
                end
            S_UNPACK: if (up_last) nxt = (after_word == S_FETCH && cnt == '0 && !trailer) ? S_FINISH : after_word;
            S_SUBWR:  nxt = (after_word == S_FETCH && cnt == '0 && !trailer) ? S_FINISH : after_word;
            S_CLEAR:  if (up_last) nxt = S_FINISH;
            S_FINISH: nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cfg_ready <= 1'b0;
            dec_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            op        <= '0;
            cnt       <= '0;
            ptr       <= '0;
            sub_en    <= 1'b0;
            sub_idx   <= '0;
            sub_data  <= '0;
`ifdef FASTPATH_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state     <= nxt;
            cfg_ready <= (nxt == S_IDLE) || (nxt == S_FETCH);
            busy      <= (nxt != S_IDLE);
            done      <= (nxt == S_FINISH);
            // zero-count and illegal headers reach FINISH without ever holding
            dec_hold  <= (nxt != S_IDLE) && (nxt != S_FINISH || dec_hold);
            sub_en    <= 1'b0;

            if (state == S_IDLE && acc) begin
                op  <= h_op;
                cnt <= h_cnt;
                ptr <= h_start;
                err <= !h_legal;
`ifdef FASTPATH_LOADER_CHECKSUM_EN
                csum <= '0;
`endif
            end

            if (state == S_FETCH && acc && !trailer) begin
                cnt <= cnt - CNT_W'(1);
`ifdef FASTPATH_LOADER_CHECKSUM_EN
                csum <= csum ^ cfg_data;
`endif
                if (op == OP_TAB) begin
                    ptr <= ptr + TAB_AW'(8);
                end else begin
                    sub_en   <= 1'b1;
                    sub_idx  <= ptr[SUB_IW-1:0];
                    sub_data <= cfg_data;
                    ptr      <= ptr + TAB_AW'(1);
                end
            end

`ifdef FASTPATH_LOADER_CHECKSUM_EN
            if (state == S_FETCH && acc && trailer && cfg_data != csum)
                err <= 1'b1;
`endif

            // bitmap clear runs alongside the first 256 table-clear cycles
            if (state == S_QUIESCE && dec_idle && op == OP_CLR) begin
                sub_en   <= 1'b1;
                sub_idx  <= '0;
                sub_data <= '0;
            end else if (state == S_CLEAR && sub_en && sub_idx != '1) begin
                sub_en  <= 1'b1;
                sub_idx <= sub_idx + SUB_IW'(1);
            end
        end
    end

    fastpath_byte_unpacker #(.AW(TAB_AW)) u_unpack (
        .clk  (clk),
        .rst  (rst),
        .load (up_load),
        .word (up_word),
        .base (up_base),
        .span (up_span),
        .wen  (tab_wen),
        .addr (tab_addr),
        .data (tab_data),
        .last (up_last)
    );

endmodule

// File: tb/tb_fastpath_optab_loader.sv
// Randomized self-checking bench for fastpath_optab_loader; expected write
// traces are computed from the command rules and compared to a write monitor.
module tb_fastpath_optab_loader;
    import fastpath_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [63:0] cfg_data = '0;
    logic        dec_hold;
    logic        dec_idle = 1'b0;
    logic        tab_wen;
    logic [11:0] tab_addr;
    logic [7:0]  tab_data;
    logic        sub_en;
    logic [7:0]  sub_idx;
    logic [63:0] sub_data;
    logic        busy, done, err;

    fastpath_optab_loader dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .dec_hold(dec_hold), .dec_idle(dec_idle),
        .tab_wen(tab_wen), .tab_addr(tab_addr), .tab_data(tab_data),
        .sub_en(sub_en), .sub_idx(sub_idx), .sub_data(sub_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [19:0] tabq[$];
    logic [71:0] subq[$];
    int done_cnt = 0, unheld = 0, both = 0, held = 0;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (tab_wen) tabq.push_back({tab_addr, tab_data});
            if (sub_en)  subq.push_back({sub_idx, sub_data});
            if (done)    done_cnt++;
            if ((tab_wen || sub_en) && !dec_hold) unheld++;
            if (tab_wen && sub_en) both++;
            if (dec_hold) held++;
        end
    end

    task automatic clear_mon();
        tabq.delete();
        subq.delete();
        done_cnt = 0; unheld = 0; both = 0; held = 0;
    endtask

    function automatic logic [63:0] hdr(input logic [3:0] op, input logic [11:0] st, input logic [15:0] n);
        return {op, st, n, 32'($urandom)};
    endfunction

    // called at a negedge; returns at the negedge after the word is taken
    task automatic send(input logic [63:0] w);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_data  = w;
        while (!cfg_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            checks++;
            $display("FAIL send: cfg_ready never rose (got %b, need 1)", cfg_ready);
        end else begin
            @(negedge clk);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit, input string name);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt < target) $display("FAIL %s done timeout: got %0d pulses, need %0d", name, done_cnt, target);
        else passes++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({cfg_ready, dec_hold, tab_wen, tab_addr, tab_data, sub_en, sub_idx, sub_data, busy, done, err} !== '0)
            $display("FAIL reset_values: got ready=%b hold=%b wen=%b sub_en=%b busy=%b done=%b err=%b, need all 0",
                     cfg_ready, dec_hold, tab_wen, sub_en, busy, done, err);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_ready: got ready=%b busy=%b, need 1/0", cfg_ready, busy);
        else passes++;
    endtask

    // TAB or SUB load; model: TAB byte k of word i -> (start+8i+k)%4096, SUB word i -> (start+i)%256
    task automatic run_load(input logic [3:0] op, input logic [11:0] start, input logic [63:0] w[$],
                            input int dly, input string name);
        logic [63:0] x = '0;
        logic [19:0] et;
        logic [71:0] es;
        int bad = 0, hb = 0, n_tab, n_sub;
        clear_mon();
        dec_idle = 1'b0;
        send(hdr(op, start, 16'(w.size())));
        repeat (dly) begin
            if (cfg_ready || !dec_hold) hb++;
            @(negedge clk);
        end
        dec_idle = 1'b1;
        foreach (w[i]) begin
            send(w[i]);
            x ^= w[i];
        end
`ifdef FASTPATH_LOADER_CHECKSUM_EN
        send(x);
`endif
        wait_done(1, 400, name);
        n_tab = (op == OP_TAB) ? 8 * w.size() : 0;
        n_sub = (op == OP_SUB) ? w.size() : 0;
        checks++;
        if (tabq.size() != n_tab || subq.size() != n_sub)
            $display("FAIL %s write_count: got tab=%0d sub=%0d, need tab=%0d sub=%0d", name, tabq.size(), subq.size(), n_tab, n_sub);
        else passes++;
        for (int i = 0; i < n_tab && i < tabq.size(); i++) begin
            et = {12'((int'(start) + i) % 4096), 8'(w[i / 8] >> (8 * (i % 8)))};
            if (tabq[i] !== et) bad++;
        end
        for (int i = 0; i < n_sub && i < subq.size(); i++) begin
            es = {8'((int'(start) + i) % 256), w[i]};
            if (subq[i] !== es) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL %s write_data: got %0d wrong writes, need 0", name, bad);
        else passes++;
        checks++;
        if (done_cnt != 1 || err !== 1'b0 || dec_hold !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s completion: got done=%0d err=%b hold=%b busy=%b, need 1/0/0/0", name, done_cnt, err, dec_hold, busy);
        else passes++;
        checks++;
        if (hb != 0 || unheld != 0 || both != 0)
            $display("FAIL %s handshake: got %0d hold gaps, %0d unheld writes, %0d dual strobes, need 0", name, hb, unheld, both);
        else passes++;
    endtask

    task automatic test_tab_random();
        logic [63:0] w[$];
        for (int it = 0; it < 4; it++) begin
            w.delete();
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) w.push_back({$urandom, $urandom});
            run_load(OP_TAB, 12'($urandom_range(0, 4095)), w, $urandom_range(0, 3), "tab_rand");
        end
    endtask

    task automatic test_sub_random();
        logic [63:0] w[$];
        for (int it = 0; it < 3; it++) begin
            w.delete();
            for (int j = 0; j < int'($urandom_range(1, 4)); j++) w.push_back({$urandom, $urandom});
            run_load(OP_SUB, 12'($urandom_range(0, 4095)), w, $urandom_range(0, 4), "sub_rand");
        end
    endtask

    task automatic test_fixed();
        logic [63:0] w[$];
        w = '{64'h0807060504030201};
        run_load(OP_TAB, 12'h010, w, 0, "tab_basic");
        w = '{{$urandom, $urandom}};
        run_load(OP_TAB, 12'hFFC, w, 1, "tab_wrap");
        w = '{64'hAAAA_5555_1234_5678, 64'hBBBB_CCCC_DDDD_EEEE};
        run_load(OP_SUB, 12'h0FF, w, 5, "sub_wrap");
    endtask

    task automatic test_clr();
        int n = 0, busy_low = 0, bad = 0;
        clear_mon();
        dec_idle = 1'b1;
        send(hdr(OP_CLR, 12'($urandom), 16'($urandom)));
        while (done_cnt < 1 && n < 6000) begin
            if (!busy) busy_low++;
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt != 1) $display("FAIL clr_done: got %0d pulses, need 1", done_cnt);
        else passes++;
        checks++;
        if (tabq.size() != 4096 || subq.size() != 256)
            $display("FAIL clr_count: got tab=%0d sub=%0d, need 4096/256", tabq.size(), subq.size());
        else passes++;
        foreach (tabq[i]) if (tabq[i] !== {12'(i), 8'h00}) bad++;
        foreach (subq[i]) if (subq[i] !== {8'(i), 64'h0}) bad++;
        checks++;
        if (bad != 0 || busy_low != 0 || unheld != 0 || err !== 1'b0)
            $display("FAIL clr_data: got %0d bad writes, %0d busy-low cycles, %0d unheld, err=%b, need 0", bad, busy_low, unheld, err);
        else passes++;
    endtask

    task automatic test_illegal();
        clear_mon();
        dec_idle = 1'b0;
        send(hdr(4'h7, 12'($urandom), 16'h0005));
        wait_done(1, 50, "illegal");
        checks++;
        if (err !== 1'b1 || done_cnt != 1 || tabq.size() != 0 || subq.size() != 0 || held != 0)
            $display("FAIL illegal_op: got err=%b done=%0d tab=%0d sub=%0d hold_cycles=%0d, need 1/1/0/0/0",
                     err, done_cnt, tabq.size(), subq.size(), held);
        else passes++;
        send(hdr(OP_TAB, 12'h123, 16'h0000));
        wait_done(2, 50, "zero_count");
        checks++;
        if (err !== 1'b0 || done_cnt != 2 || tabq.size() != 0 || held != 0)
            $display("FAIL err_clear: got err=%b done=%0d tab=%0d hold_cycles=%0d, need 0/2/0/0", err, done_cnt, tabq.size(), held);
        else passes++;
    endtask

    task automatic test_mid_reset();
        int n = 0;
        clear_mon();
        dec_idle = 1'b1;
        send(hdr(OP_TAB, 12'h200, 16'h0002));
        send({$urandom, $urandom});
        while (tabq.size() < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({cfg_ready, dec_hold, tab_wen, tab_addr, tab_data, sub_en, sub_idx, sub_data, busy, done, err} !== '0)
            $display("FAIL mid_reset_values: got ready=%b hold=%b wen=%b addr=%h busy=%b, need all 0",
                     cfg_ready, dec_hold, tab_wen, tab_addr, busy);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || dec_hold !== 1'b0 || tabq.size() != 3)
            $display("FAIL mid_reset_recover: got ready=%b busy=%b hold=%b writes=%0d, need 1/0/0/3",
                     cfg_ready, busy, dec_hold, tabq.size());
        else passes++;
        send(hdr(OP_SUB, 12'h000, 16'h0000));
        wait_done(1, 50, "after_reset");
    endtask

`ifdef FASTPATH_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clear_mon();
        dec_idle = 1'b1;
        send(hdr(OP_SUB, 12'h010, 16'h0001));
        send(64'h5A);
        send(64'h5B);
        wait_done(1, 50, "checksum");
        checks++;
        if (err !== 1'b1 || done_cnt != 1 || subq.size() != 1)
            $display("FAIL checksum_bad: got err=%b done=%0d chunks=%0d, need 1/1/1", err, done_cnt, subq.size());
        else passes++;
        checks++;
        if (subq.size() == 0 || subq[0] !== {8'h10, 64'h5A})
            $display("FAIL checksum_chunk: got %0d entries, first %h, need %h", subq.size(),
                     (subq.size() != 0) ? subq[0] : 72'h0, {8'h10, 64'h5A});
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_fixed();
        test_tab_random();
        test_sub_random();
        test_clr();
        test_illegal();
        test_mid_reset();
`ifdef FASTPATH_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
